// File: rtl/calc_entry_sequencer.sv
// Calculator entry sequencer: debounces operator switches, assembles "A op B =" from keypad
// digits, drives the ALU handshake and echoes accepted symbols to the LCD via a 4-deep queue.
// Optional build macro CALC_CHAIN_EN: an operator after a result chains it in as operand A.
module calc_entry_sequencer #(
    parameter int WIDTH   = 16,
    parameter int DIGITS  = 3,
    parameter int DEB_CYC = 4
) (
    input  logic             clk_100hz,
    input  logic             rst,
    input  logic [7:0]       i_sw_dip,
    input  logic             i_key_valid,
    input  logic [3:0]       i_key_digit,
    input  logic             i_alu_ack,
    input  logic [WIDTH-1:0] i_alu_result,
    input  logic             i_alu_err,
    input  logic             i_lcd_busy,
    output logic [7:0]       o_led,
    output logic             o_lcd_wr,
    output logic [7:0]       o_lcd_char,
    output logic             o_lcd_clr,
    output logic             o_alu_req,
    output logic [2:0]       o_alu_op,
    output logic [WIDTH-1:0] o_opa,
    output logic [WIDTH-1:0] o_opb,
    output logic [WIDTH-1:0] o_result,
    output logic             o_result_valid,
    output logic             o_err,
    output logic             o_ovf
);

    localparam int CW = $clog2(DEB_CYC + 1);
    localparam int NW = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {S_A, S_B, S_WEQ, S_EXEC, S_DONE} state_t;
    typedef enum logic [3:0] {
        ACT_NONE, ACT_DIG_A, ACT_DIG_B, ACT_OP, ACT_FACT, ACT_EQ, ACT_ACK, ACT_RESTART, ACT_CHAIN
    } act_t;

    function automatic logic [2:0] op_code(input logic [7:0] sw);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 1; i < 8; i++)
            if (sw[i]) c = 3'(7 - i);
        return c;
    endfunction

    function automatic logic [7:0] op_char(input logic [2:0] op);
        logic [7:0] c;
        case (op)
            3'd0:    c = 8'h2B;
            3'd1:    c = 8'h2D;
            3'd2:    c = 8'hD7;
            3'd3:    c = 8'h2F;
            3'd4:    c = 8'hF7;
            3'd5:    c = 8'h5E;
            default: c = 8'h21;
        endcase
        return c;
    endfunction

    // ---------------- switch debounce ----------------
    logic [7:0]    r_sync, r_cand, r_led, r_op_sw;
    logic [CW-1:0] r_cnt;
    logic          r_op_pend;
    logic          w_accept, w_op_evt, w_op_take;
    logic [7:0]    w_clean;

    assign w_accept = (r_sync == r_cand) && (r_cnt == CW'(DEB_CYC - 1));
    assign w_clean  = $onehot(r_cand) ? r_cand : 8'h00;
    assign w_op_evt = w_accept && (w_clean != 8'h00) && (w_clean != r_led);

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            r_sync    <= 8'h00;
            r_cand    <= 8'h00;
            r_cnt     <= CW'(DEB_CYC);
            r_led     <= 8'h00;
            r_op_pend <= 1'b0;
            r_op_sw   <= 8'h00;
        end else begin
            r_sync <= i_sw_dip;
            if (r_sync != r_cand) begin
                r_cand <= r_sync;
                r_cnt  <= CW'(1);
            end else if (r_cnt < CW'(DEB_CYC)) begin
                r_cnt <= r_cnt + CW'(1);
            end
            if (w_accept) r_led <= w_clean;
            // a pending operator waits out any cycle that carries a digit
            if (w_op_evt) begin
                r_op_pend <= 1'b1;
                r_op_sw   <= w_clean;
            end else if (w_op_take) begin
                r_op_pend <= 1'b0;
            end
        end
    end

    // ---------------- event decode ----------------
    state_t           r_state, w_nxt;
    act_t             w_act;
    logic [7:0]       w_chr;
    logic             w_key, w_is_eq, w_is_fact, w_is_bin;
    logic [2:0]       w_opc;
    logic [NW-1:0]    r_na, r_nb;
    logic [WIDTH-1:0] r_opa, r_opb, r_result, w_dig;
    logic [2:0]       r_op;
    logic             r_err, r_res_vld, r_ovf, r_clr;
    logic             w_full, w_echo_ev, w_drop, w_do, w_clr, w_push, w_pop, w_ovf;

    assign w_key     = i_key_valid && (i_key_digit < 4'd10);
    assign w_op_take = r_op_pend && !w_key;
    assign w_is_eq   = (r_op_sw == 8'h01);
    assign w_is_fact = (r_op_sw == 8'h02);
    assign w_is_bin  = |r_op_sw[7:2];
    assign w_opc     = op_code(r_op_sw);
    assign w_dig     = {{(WIDTH-4){1'b0}}, i_key_digit};

    always_comb begin : p_act
        w_act = ACT_NONE;
        w_chr = 8'h20;
        case (r_state)
            S_A: begin
                if (w_key) begin
                    if (r_na < NW'(DIGITS)) begin
                        w_act = ACT_DIG_A;
                        w_chr = 8'h30 + {4'h0, i_key_digit};
                    end
                end else if (w_op_take && (r_na != '0) && (w_is_bin || w_is_fact)) begin
                    w_act = w_is_fact ? ACT_FACT : ACT_OP;
                    w_chr = op_char(w_opc);
                end
            end
            S_B: begin
                if (w_key) begin
                    if (r_nb < NW'(DIGITS)) begin
                        w_act = ACT_DIG_B;
                        w_chr = 8'h30 + {4'h0, i_key_digit};
                    end
                end else if (w_op_take && w_is_eq && (r_nb != '0)) begin
                    w_act = ACT_EQ;
                    w_chr = 8'h3D;
                end
            end
            S_WEQ: begin
                if (!w_key && w_op_take && w_is_eq) begin
                    w_act = ACT_EQ;
                    w_chr = 8'h3D;
                end
            end
            S_EXEC: begin
                if (i_alu_ack) begin
                    w_act = ACT_ACK;
                    w_chr = 8'h45;
                end
            end
            S_DONE: begin
                if (w_key) begin
                    w_act = ACT_RESTART;
                    w_chr = 8'h30 + {4'h0, i_key_digit};
                end
`ifdef CALC_CHAIN_EN
                else if (w_op_take && !r_err && (w_is_bin || w_is_fact)) begin
                    w_act = ACT_CHAIN;
                    w_chr = op_char(w_opc);
                end
`endif
            end
            default: ;
        endcase
    end

    // restart/chain flush the queue first, so only plain echoes can be dropped
    assign w_echo_ev = (w_act == ACT_DIG_A) || (w_act == ACT_DIG_B) || (w_act == ACT_OP) ||
                       (w_act == ACT_FACT) || (w_act == ACT_EQ);
    assign w_drop    = w_echo_ev && w_full;
    assign w_do      = (w_act != ACT_NONE) && !w_drop;
    assign w_clr     = (w_act == ACT_RESTART) || (w_act == ACT_CHAIN);
    assign w_push    = (w_echo_ev && !w_full) || w_clr ||
                       ((w_act == ACT_ACK) && i_alu_err && !w_full);
    assign w_ovf     = w_drop || ((w_act == ACT_ACK) && i_alu_err && w_full);

    // ---------------- FSM ----------------
    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) r_state <= S_A;
        else     r_state <= w_nxt;
    end

    always_comb begin : p_nxt
        w_nxt = r_state;
        if (w_do) begin
            case (w_act)
                ACT_OP:      w_nxt = S_B;
                ACT_FACT:    w_nxt = S_WEQ;
                ACT_EQ:      w_nxt = S_EXEC;
                ACT_ACK:     w_nxt = S_DONE;
                ACT_RESTART: w_nxt = S_A;
                ACT_CHAIN:   w_nxt = w_is_fact ? S_WEQ : S_B;
                default:     w_nxt = r_state;
            endcase
        end
    end

    always_comb begin : p_out
        o_alu_req = (r_state == S_EXEC);
    end

    // ---------------- operand / result datapath ----------------
    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            r_opa     <= '0;
            r_opb     <= '0;
            r_na      <= '0;
            r_nb      <= '0;
            r_op      <= 3'd0;
            r_result  <= '0;
            r_err     <= 1'b0;
            r_res_vld <= 1'b0;
            r_ovf     <= 1'b0;
            r_clr     <= 1'b0;
        end else begin
            r_res_vld <= 1'b0;
            r_ovf     <= w_ovf;
            r_clr     <= w_clr;
            if (w_do) begin
                case (w_act)
                    ACT_DIG_A: begin
                        r_opa <= (r_opa << 3) + (r_opa << 1) + w_dig;
                        r_na  <= r_na + NW'(1);
                    end
                    ACT_DIG_B: begin
                        r_opb <= (r_opb << 3) + (r_opb << 1) + w_dig;
                        r_nb  <= r_nb + NW'(1);
                    end
                    ACT_OP, ACT_FACT: begin
                        r_op  <= w_opc;
                        r_opb <= '0;
                        r_nb  <= '0;
                    end
                    ACT_ACK: begin
                        r_result  <= i_alu_result;
                        r_err     <= i_alu_err;
                        r_res_vld <= 1'b1;
                    end
                    ACT_RESTART: begin
                        r_opa <= w_dig;
                        r_na  <= NW'(1);
                        r_err <= 1'b0;
                    end
                    ACT_CHAIN: begin
                        r_opa <= r_result;
                        r_na  <= NW'(DIGITS);
                        r_op  <= w_opc;
                        r_opb <= '0;
                        r_nb  <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end

    // ---------------- LCD write queue ----------------
    logic [7:0] r_q [4];
    logic [1:0] r_wp, r_rp;
    logic [2:0] r_qn;
    logic       r_lcd_wr;
    logic [7:0] r_lcd_char;

    assign w_full = (r_qn == 3'd4);
    // the !r_lcd_wr term enforces one idle cycle between writes
    assign w_pop  = (r_qn != 3'd0) && !i_lcd_busy && !r_lcd_wr && !w_clr;

    always_ff @(posedge clk_100hz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_q[i] <= 8'h00;
            r_wp       <= 2'd0;
            r_rp       <= 2'd0;
            r_qn       <= 3'd0;
            r_lcd_wr   <= 1'b0;
            r_lcd_char <= 8'h20;
        end else begin
            r_lcd_wr <= w_pop;
            if (w_pop) r_lcd_char <= r_q[r_rp];
            if (w_clr) begin
                r_q[0] <= w_chr;
                r_rp   <= 2'd0;
                r_wp   <= 2'd1;
                r_qn   <= 3'd1;
            end else begin
                if (w_push) begin
                    r_q[r_wp] <= w_chr;
                    r_wp      <= r_wp + 2'd1;
                end
                if (w_pop) r_rp <= r_rp + 2'd1;
                case ({w_push, w_pop})
                    2'b10:   r_qn <= r_qn + 3'd1;
                    2'b01:   r_qn <= r_qn - 3'd1;
                    default: r_qn <= r_qn;
                endcase
            end
        end
    end

    assign o_led          = r_led;
    assign o_lcd_wr       = r_lcd_wr;
    assign o_lcd_char     = r_lcd_char;
    assign o_lcd_clr      = r_clr;
    assign o_alu_op       = r_op;
    assign o_opa          = r_opa;
    assign o_opb          = r_opb;
    assign o_result       = r_result;
    assign o_result_valid = r_res_vld;
    assign o_err          = r_err;
    assign o_ovf          = r_ovf;

endmodule

// File: tb/tb_calc_entry_sequencer.sv
// Scoreboard bench for calc_entry_sequencer: expected LCD characters and ALU results are queued
// as stimulus is issued; a negedge monitor pops and compares whenever the DUT strobes an output.
module tb_calc_entry_sequencer;

    localparam int WIDTH   = 16;
    localparam int DIGITS  = 3;
    localparam int DEB_CYC = 4;

    logic             clk_100hz = 1'b0;
    logic             rst = 1'b1;
    logic [7:0]       i_sw_dip = 8'h00;
    logic             i_key_valid = 1'b0;
    logic [3:0]       i_key_digit = 4'd0;
    logic             i_alu_ack = 1'b0;
    logic [WIDTH-1:0] i_alu_result = '0;
    logic             i_alu_err = 1'b0;
    logic             i_lcd_busy = 1'b0;
    logic [7:0]       o_led, o_lcd_char;
    logic             o_lcd_wr, o_lcd_clr, o_alu_req, o_result_valid, o_err, o_ovf;
    logic [2:0]       o_alu_op;
    logic [WIDTH-1:0] o_opa, o_opb, o_result;

    calc_entry_sequencer #(.WIDTH(WIDTH), .DIGITS(DIGITS), .DEB_CYC(DEB_CYC)) dut (
        .clk_100hz(clk_100hz), .rst(rst), .i_sw_dip(i_sw_dip),
        .i_key_valid(i_key_valid), .i_key_digit(i_key_digit),
        .i_alu_ack(i_alu_ack), .i_alu_result(i_alu_result), .i_alu_err(i_alu_err),
        .i_lcd_busy(i_lcd_busy), .o_led(o_led), .o_lcd_wr(o_lcd_wr), .o_lcd_char(o_lcd_char),
        .o_lcd_clr(o_lcd_clr), .o_alu_req(o_alu_req), .o_alu_op(o_alu_op), .o_opa(o_opa),
        .o_opb(o_opb), .o_result(o_result), .o_result_valid(o_result_valid), .o_err(o_err),
        .o_ovf(o_ovf)
    );

    always #5 clk_100hz = ~clk_100hz;

    int          n_tests = 0, n_fail = 0;
    logic [7:0]  exp_lcd[$];
    logic [16:0] exp_res[$];
    int          n_clr = 0, exp_clr = 0, n_ovf = 0, exp_ovf = 0, n_res = 0, exp_nres = 0, n_wr = 0;
    logic        prev_wr = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    // monitor
    always @(negedge clk_100hz) begin
        if (!rst) begin
            if (o_lcd_wr) begin
                n_wr++;
                check("lcd_gap", {31'd0, prev_wr}, 32'd0);
                if (exp_lcd.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL lcd_unexpected: got 0x%0h, want no write", o_lcd_char);
                end else begin
                    check("lcd_char", {24'd0, o_lcd_char}, {24'd0, exp_lcd.pop_front()});
                end
            end
            if (o_result_valid) begin
                n_res++;
                if (exp_res.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL result_unexpected: got 0x%0h, want no result", o_result);
                end else begin
                    check("result", {15'd0, o_err, o_result}, {15'd0, exp_res.pop_front()});
                end
            end
            if (o_lcd_clr) n_clr++;
            if (o_ovf) n_ovf++;
        end
        prev_wr = o_lcd_wr;
    end

    task automatic key(input logic [3:0] d, input bit echo);
        if (echo) exp_lcd.push_back(8'h30 + {4'h0, d});
        @(negedge clk_100hz);
        i_key_valid = 1'b1;
        i_key_digit = d;
        @(negedge clk_100hz);
        i_key_valid = 1'b0;
        @(negedge clk_100hz);
    endtask

    task automatic sw(input logic [7:0] v, input logic [7:0] c, input bit echo);
        if (echo) exp_lcd.push_back(c);
        @(negedge clk_100hz);
        i_sw_dip = v;
        repeat (DEB_CYC + 3) @(negedge clk_100hz);
    endtask

    task automatic wait_req();
        int k = 0;
        while (o_alu_req !== 1'b1 && k < 50) begin
            @(negedge clk_100hz);
            k++;
        end
        check("alu_req_rise", {31'd0, o_alu_req}, 32'd1);
    endtask

    task automatic ack(input logic [15:0] r, input logic e, input bit expect_res);
        if (expect_res) begin
            exp_res.push_back({e, r});
            exp_nres++;
        end
        @(negedge clk_100hz);
        i_alu_ack    = 1'b1;
        i_alu_result = r;
        i_alu_err    = e;
        @(negedge clk_100hz);
        i_alu_ack = 1'b0;
        i_alu_err = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_lcd.size() != 0 && k < 200) begin
            @(negedge clk_100hz);
            k++;
        end
        check("lcd_drain", exp_lcd.size(), 32'd0);
        exp_lcd.delete();
        repeat (2) @(negedge clk_100hz);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_led"}, {24'd0, o_led}, 32'h00);
        check({tag, "_lcd_char"}, {24'd0, o_lcd_char}, 32'h20);
        check({tag, "_strobes"}, {28'd0, o_lcd_wr, o_lcd_clr, o_result_valid, o_ovf}, 32'd0);
        check({tag, "_req_err"}, {30'd0, o_alu_req, o_err}, 32'd0);
        check({tag, "_op"}, {29'd0, o_alu_op}, 32'd0);
        check({tag, "_opa"}, {16'd0, o_opa}, 32'd0);
        check({tag, "_opb"}, {16'd0, o_opb}, 32'd0);
        check({tag, "_result"}, {16'd0, o_result}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        repeat (3) @(negedge clk_100hz);
        check_reset("por");
        rst = 1'b0;
        @(negedge clk_100hz);

        // 12 + 7 =, invalid key code 12 ignored
        key(4'd1, 1); key(4'd12, 0); key(4'd2, 1);
        sw(8'h80, 8'h2B, 1);
        key(4'd7, 1);
        sw(8'h01, 8'h3D, 1);
        check("t1_led", {24'd0, o_led}, 32'h01);
        wait_req();
        check("t1_opa", {16'd0, o_opa}, 32'd12);
        check("t1_opb", {16'd0, o_opb}, 32'd7);
        check("t1_op", {29'd0, o_alu_op}, 32'd0);
        ack(16'd19, 1'b0, 1);
        check("t1_req_fall", {31'd0, o_alu_req}, 32'd0);

        // restart with 8, bouncing '/', bad switch code, 8 / 2 =
        wait_drain();
        exp_clr++;
        key(4'd8, 1);
        @(negedge clk_100hz) i_sw_dip = 8'h10;
        @(negedge clk_100hz) i_sw_dip = 8'h00;
        @(negedge clk_100hz) i_sw_dip = 8'h10;
        @(negedge clk_100hz) i_sw_dip = 8'h00;
        exp_lcd.push_back(8'h2F);
        @(negedge clk_100hz) i_sw_dip = 8'h10;
        repeat (DEB_CYC) @(negedge clk_100hz);
        check("t2_led_hold", {24'd0, o_led}, 32'h01);
        @(negedge clk_100hz);
        check("t2_led_upd", {24'd0, o_led}, 32'h10);
        repeat (6) @(negedge clk_100hz);
        sw(8'h11, 8'h00, 0);
        check("t2_led_bad", {24'd0, o_led}, 32'h00);
        key(4'd2, 1);
        sw(8'h01, 8'h3D, 1);
        wait_req();
        check("t2_opa", {16'd0, o_opa}, 32'd8);
        check("t2_opb", {16'd0, o_opb}, 32'd2);
        check("t2_op", {29'd0, o_alu_op}, 32'd3);
        ack(16'd4, 1'b0, 1);

        // 5 ! = with error result
        wait_drain();
        exp_clr++;
        key(4'd5, 1);
        sw(8'h02, 8'h21, 1);
        sw(8'h01, 8'h3D, 1);
        wait_req();
        check("t3_op", {29'd0, o_alu_op}, 32'd6);
        check("t3_opb", {16'd0, o_opb}, 32'd0);
        check("t3_opa", {16'd0, o_opa}, 32'd5);
        exp_lcd.push_back(8'h45);
        ack(16'd0, 1'b1, 1);
        check("t3_err", {31'd0, o_err}, 32'd1);

        // queue fill while LCD busy, digit limit, overflow drop
        wait_drain();
        i_lcd_busy = 1'b1;
        w0 = n_wr;
        exp_clr++;
        key(4'd1, 1);
        check("t4_err_clr", {31'd0, o_err}, 32'd0);
        key(4'd2, 1); key(4'd3, 1); key(4'd4, 0);
        sw(8'h80, 8'h2B, 1);
        exp_ovf++;
        key(4'd9, 0);
        check("t4_ovf", n_ovf, exp_ovf);
        check("t4_no_wr_busy", n_wr, w0);
        i_lcd_busy = 1'b0;
        wait_drain();
        check("t4_wr_count", n_wr, w0 + 4);
        key(4'd6, 1);
        sw(8'h01, 8'h3D, 1);
        wait_req();
        check("t4_opa", {16'd0, o_opa}, 32'd123);
        check("t4_opb", {16'd0, o_opb}, 32'd6);
        ack(16'd129, 1'b0, 1);

        // digit and operator in the same cycle: digit first
        wait_drain();
        exp_clr++;
        key(4'd2, 1);
        exp_lcd.push_back(8'h33);
        exp_lcd.push_back(8'h2B);
        @(negedge clk_100hz) i_sw_dip = 8'h80;
        repeat (DEB_CYC + 1) @(negedge clk_100hz);
        i_key_valid = 1'b1;
        i_key_digit = 4'd3;
        @(negedge clk_100hz) i_key_valid = 1'b0;
        repeat (3) @(negedge clk_100hz);
        key(4'd4, 1);
        sw(8'h01, 8'h3D, 1);
        wait_req();
        check("t5_opa", {16'd0, o_opa}, 32'd23);
        check("t5_opb", {16'd0, o_opb}, 32'd4);

        // reset during S_EXEC, stale ack afterwards
        wait_drain();
        @(negedge clk_100hz);
        rst = 1'b1;
        i_sw_dip = 8'h00;
        @(negedge clk_100hz);
        check_reset("t5_rst");
        @(negedge clk_100hz) rst = 1'b0;
        ack(16'd77, 1'b0, 0);
        repeat (3) @(negedge clk_100hz);
        check("t5_no_result", n_res, exp_nres);
        check("t5_req_low", {31'd0, o_alu_req}, 32'd0);

        // operator after a result
        key(4'd1, 1); key(4'd2, 1);
        sw(8'h80, 8'h2B, 1);
        key(4'd7, 1);
        sw(8'h01, 8'h3D, 1);
        wait_req();
        ack(16'd19, 1'b0, 1);
        wait_drain();
`ifdef CALC_CHAIN_EN
        exp_clr++;
        sw(8'h40, 8'h2D, 1);
        key(4'd4, 1);
        sw(8'h01, 8'h3D, 1);
        wait_req();
        check("t6_opa", {16'd0, o_opa}, 32'd19);
        check("t6_opb", {16'd0, o_opb}, 32'd4);
        check("t6_op", {29'd0, o_alu_op}, 32'd1);
        ack(16'd15, 1'b0, 1);
`else
        sw(8'h40, 8'h00, 0);
        check("t6_led", {24'd0, o_led}, 32'h40);
        check("t6_req_idle", {31'd0, o_alu_req}, 32'd0);
        exp_clr++;
        key(4'd4, 1);
        check("t6_restart_opa", {16'd0, o_opa}, 32'd4);
`endif

        wait_drain();
        check("clr_count", n_clr, exp_clr);
        check("ovf_count", n_ovf, exp_ovf);
        check("res_count", n_res, exp_nres);
        check("res_queue_empty", exp_res.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
